fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage on the consumer side of the program counter. It takes the current address from `program_counter`, issues in-order read requests to instruction memory, and pairs each returned word with its address. Matched words sit in a small buffer and are delivered to decode over a valid/ready handshake. A flush, raised on a taken jump, discards everything buffered and everything still in flight.

## Interface
- WIDTH, 32, address and instruction width in bits
- DEPTH, 4, max entries outstanding plus buffered (power of 2, ≥2)

- clk  in  1  clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- i_pc  in  WIDTH  current fetch address from program counter
- o_pc_step  out  1  request accepted this cycle; PC must advance at this edge
- i_flush  in  1  redirect: PC loads a new target at this edge; drop old stream
- o_mem_req_valid  out  1  read request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_req_addr  out  WIDTH  read address (= i_pc)
- i_mem_rsp_valid  in  1  read data valid; in order, latency ≥1, no backpressure
- i_mem_rsp_data  in  WIDTH  read data
- o_inst_valid  out  1  instruction available to decode
- i_inst_ready  in  1  decode accepts instruction
- o_inst  out  WIDTH  instruction word
- o_inst_pc  out  WIDTH  address of o_inst

## Operation
- Circular buffer of DEPTH entries, each holding {pc, data, filled}; head, tail and fill pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Counters are $clog2(DEPTH+1) bits wide:
  - `count`: allocated entries.
  - `drop`: responses still owed to a flushed stream.
- o_mem_req_valid = !i_flush && (count + drop < DEPTH).
- o_mem_req_addr = i_pc, combinational.
- Request accept (valid && ready):
  - allocate the tail entry with pc = i_pc, filled = 0;
  - tail++, count++;
  - o_pc_step = 1 in the same cycle.
- Response:
  - if drop > 0: discard, drop--;
  - else: write data into the oldest unfilled entry, set filled, fill pointer++.
- o_inst_valid = count > 0 && head.filled.
- o_inst and o_inst_pc come from the head entry.
- Handshake (valid && ready, no flush): head++, count--.
- Flush:
  - drop ← drop + (responses outstanding for allocated entries) − (response dropped or consumed this cycle);
  - count, head, tail, fill pointer ← 0; all filled bits ← 0.
- Simultaneous events:
  - flush + response in the same cycle: the response belongs to the old stream and is dropped;
  - flush + decode handshake: flush wins and the entry is discarded;
  - accept + handshake in the same cycle: count is unchanged;
  - accept + response into the same empty slot cannot occur, because latency is ≥1.
- No response may arrive while no response is outstanding. This is a protocol violation; behaviour is undefined and should be flagged by an assertion.

## Timing
- Reset (async, immediate):
  - count = drop = 0, pointers = 0, filled bits = 0;
  - o_inst_valid = 0, o_pc_step = 0;
  - o_mem_req_valid = 1 once reset is released (unless i_flush).
- Request accepted at edge N: the PC presents the next address at N+1, giving back-to-back issue of one request per cycle.
- Response at edge M with the entry at head: o_inst_valid = 1 from cycle M+1. Fetch-to-decode latency is memory latency + 1.
- Steady-state throughput is 1 instruction/cycle when memory latency ≤ DEPTH−1 and decode is always ready.
- Full (count + drop = DEPTH): o_mem_req_valid = 0 and the PC holds. Issue resumes the cycle after a handshake or a dropped response frees a slot.
- After a flush at edge F, the first new request can issue in cycle F+1 at the new PC, subject to the credit left after drop.
- Reset asserted mid-stream clears all state. The memory side must also be reset, so stale responses after reset are not handled.

## Test plan
- Single fetch, memory latency 1:
  - stimulus: i_pc = 0x100, rsp data 0xDEADBEEF;
  - response: o_pc_step pulses once; o_inst = 0xDEADBEEF with o_inst_pc = 0x100, valid 2 cycles after request accept.
- Streaming, latency 2, decode always ready, PC 0..7:
  - response: 8 instructions in order with matching pcs; o_mem_req_valid never drops after the pipeline fills.
- Backpressure:
  - stimulus: i_inst_ready = 0, DEPTH = 4, latency 1;
  - response: exactly 4 requests accepted, then o_mem_req_valid = 0 and o_pc_step = 0; raising ready drains 4 words in order and issue resumes.
- Flush with in-flight requests:
  - stimulus: 3 requests outstanding (latency 5), flush, PC jumps to 0x40;
  - response: the 3 old responses are discarded; first o_inst_pc = 0x40; no stale word ever reaches o_inst.
- Flush coinciding with a response and with a decode handshake:
  - response: the response is dropped; the head is not delivered; drop and count are correct afterward (credit returns to DEPTH once drained).
- Async reset mid-stream:
  - stimulus: n_rst low while 2 entries are buffered;
  - response: o_inst_valid = 0 immediately; after release, fetch restarts from the current i_pc.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order reads at the PC, pairs returned words with
// their addresses in a small circular buffer and hands them to decode.
module fetch_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [WIDTH-1:0] i_pc,
    output logic             o_pc_step,
    input  logic             i_flush,
    output logic             o_mem_req_valid,
    input  logic             i_mem_req_ready,
    output logic [WIDTH-1:0] o_mem_req_addr,
    input  logic             i_mem_rsp_valid,
    input  logic [WIDTH-1:0] i_mem_rsp_data,
    output logic             o_inst_valid,
    input  logic             i_inst_ready,
    output logic [WIDTH-1:0] o_inst,
    output logic [WIDTH-1:0] o_inst_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0]    head, tail, fptr;
    // pend: allocated entries still waiting for their response
    logic [CW-1:0]    count, drop, pend;
    logic [CW:0]      used;
    logic             run, accept, hs, rsp_keep, rsp_drop;

    assign used            = {1'b0, count} + {1'b0, drop};
    assign o_mem_req_valid = run && !i_flush && (used < DEPTH_C);
    assign o_mem_req_addr  = i_pc;
    assign accept          = o_mem_req_valid && i_mem_req_ready;
    assign o_pc_step       = accept;

    assign o_inst_valid = (count != '0) && filled[head];
    assign o_inst       = data_mem[head];
    assign o_inst_pc    = pc_mem[head];
    assign hs           = o_inst_valid && i_inst_ready && !i_flush;

    assign rsp_drop = i_mem_rsp_valid && (drop != '0);
    assign rsp_keep = i_mem_rsp_valid && (drop == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run    <= 1'b0;
            head   <= '0;
            tail   <= '0;
            fptr   <= '0;
            count  <= '0;
            drop   <= '0;
            pend   <= '0;
            filled <= '0;
        end else if (i_flush) begin
            // Everything owed to the old stream, minus the one arriving now.
            drop   <= drop + pend - CW'(i_mem_rsp_valid);
            head   <= '0;
            tail   <= '0;
            fptr   <= '0;
            count  <= '0;
            pend   <= '0;
            filled <= '0;
        end else begin
            run <= 1'b1;
            if (accept) begin
                tail         <= tail + PW'(1);
                filled[tail] <= 1'b0;
            end
            if (rsp_keep) begin
                filled[fptr] <= 1'b1;
                fptr         <= fptr + PW'(1);
            end
            if (rsp_drop)
                drop <= drop - CW'(1);
            if (hs)
                head <= head + PW'(1);
            count <= count + CW'(accept) - CW'(hs);
            pend  <= pend + CW'(accept) - CW'(rsp_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            pc_mem[tail] <= i_pc;
        if (rsp_keep && !i_flush)
            data_mem[fptr] <= i_mem_rsp_data;
    end

    a_rsp_owed: assert property (@(posedge clk) disable iff (!n_rst)
        i_mem_rsp_valid |-> (pend != '0 || drop != '0));

endmodule
